apb_config_slave: RTL and testbench
===================================

// Module: apb_config_slave
// PURPOSE
//  APB3 slave front-end for the configuration memory; sits between the APB interconnect and config_mem's APB port.
//  Decodes psel/penable, range-checks the word address and gates writes on config mode.
//  Drives a one-cycle memory write strobe and captures registered read data.
//  Returns pready/pslverr with fixed wait states.
// PARAMETERS
//  K   64  number of 32-bit config words; valid word addresses 0..K-1
//  AW  16  APB address width (paddr is a word index, not a byte address)
// PORTS
//  pclk           in   1   single clock; all logic on posedge
//  prstn          in   1   asynchronous active-low reset
//  psel           in   1   APB select
//  penable        in   1   APB access phase
//  pwrite         in   1   1=write, 0=read
//  paddr          in   AW  APB word address
//  pwdata         in   32  APB write data
//  config_mode    in   1   system in config state; writes permitted only when 1
//  prdata         out  32  APB read data (registered)
//  pready         out  1   transfer complete (registered)
//  pslverr        out  1   error response, valid only with pready
//  mem_paddr      out  AW  address to config_mem
//  mem_pwdata     out  32  write data to config_mem
//  mem_pwrite     out  1   config_mem write control; pulsed for writes only
//  mem_wr_en      out  1   config_mem config_state_write_enable; pulsed with mem_pwrite
//  mem_prdata     in   32  config_mem prdata (1-cycle registered read)
//  err_count      out  8   saturating count of pslverr responses
// BEHAVIOUR
//  Reset (prstn=0, async): state=IDLE; prdata=0, pready=0, pslverr=0, mem_paddr=0, mem_pwdata=0,
//   mem_pwrite=0, mem_wr_en=0, err_count=0. Internal address/data/direction latches cleared.
//  FSM states: IDLE, MEM, CAP, DONE.
//  IDLE: on psel=1 && penable=0 (setup phase), latch paddr, pwdata and pwrite -> MEM.
//   err = (paddr >= K) || (pwrite && !config_mode), where config_mode is sampled at setup.
//  MEM (1 cycle): mem_paddr = err ? 0 : latched addr; mem_pwdata = latched data.
//   Write && !err: mem_pwrite=1 and mem_wr_en=1 for exactly this cycle -> DONE.
//   Write && err: no strobe -> DONE.
//   Read: mem_pwrite=0 -> CAP.
//  CAP (1 cycle): mem_prdata now holds the read word. prdata_q <= err ? 0 : mem_prdata -> DONE.
//  DONE (1 cycle): pready=1; pslverr=err; prdata=prdata_q for reads, 0 for writes.
//   If err, err_count += 1, saturating at 255. Then -> IDLE.
//   pready and pslverr are 0 in every other state.
//  Latency from setup edge to pready high: write = 2 cycles, read = 3 cycles.
//   A back-to-back setup phase is accepted in the cycle after DONE.
//  mem_pwrite and mem_wr_en are 0 outside MEM. The config_mem port therefore defaults to read,
//   which is harmless.
//  psel deasserted in MEM or CAP: abort -> IDLE, no pready. A write strobe already issued is not undone.
//  penable=1 while in IDLE, or psel without a setup phase: ignored; no strobe, no response.
//  config_mode changing after setup: no effect on the current transfer.
//  Reset asserted mid-transfer: immediate return to IDLE with all outputs at their reset values.
//  Upper address bits beyond log2(K) are not aliased: any paddr >= K is an error.
// TESTING
//  1. config_mode=1; write paddr=5, pwdata=0xDEADBEEF -> mem_pwrite/mem_wr_en high for one cycle,
//     mem_paddr=5; pready at setup+2; pslverr=0.
//  2. Read paddr=5 (model returns 0xDEADBEEF) -> pready at setup+3, prdata=0xDEADBEEF, pslverr=0.
//  3. config_mode=0; write paddr=3 -> no strobe; pready with pslverr=1; err_count 0->1.
//  4. Read paddr=64 with K=64 -> mem_paddr=0, prdata=0, pslverr=1; 300 such errors -> err_count=255.
//  5. psel dropped in CAP -> back to IDLE, no pready; the next read of paddr=5 completes normally.
//  6. prstn asserted in MEM of a write -> all outputs 0 the same cycle; memory word left unchanged.

Source files
------------

// File: rtl/apb_config_slave_if.sv
// APB3 bus bundle between the interconnect (master) and the config slave front-end.
// Word-addressed: paddr carries a word index, not a byte address.
interface apb_config_slave_if #(
   parameter int unsigned AW = 16
) ();
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [31:0]   pwdata;
   logic [31:0]   prdata;
   logic          pready;
   logic          pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_config_slave.sv
// APB3 slave front-end for config_mem: range/mode checks, one-cycle write strobe,
// registered read capture and fixed-latency pready/pslverr with a saturating error counter.
module apb_config_slave #(
   parameter int unsigned K  = 64,
   parameter int unsigned AW = 16
) (
   input  logic                pclk,
   input  logic                prstn,
   apb_config_slave_if.slave   apb,
   input  logic                config_mode,
   output logic [AW-1:0]       mem_paddr,
   output logic [31:0]         mem_pwdata,
   output logic                mem_pwrite,
   output logic                mem_wr_en,
   input  logic [31:0]         mem_prdata,
   output logic [7:0]          err_count
);

   localparam int unsigned DW     = 32;
   localparam int unsigned EW     = 8;
   localparam logic [AW-1:0] K_ADDR = AW'(K);
   localparam logic [EW-1:0] ECNT_MAX = {EW{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEM  = 2'd1,
      ST_CAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic            write_q, write_d;
   logic            err_q, err_d;
   logic [AW-1:0]   mem_paddr_q, mem_paddr_d;
   logic [DW-1:0]   mem_pwdata_q, mem_pwdata_d;
   logic            mem_pwrite_q, mem_pwrite_d;
   logic            mem_wr_en_q, mem_wr_en_d;
   logic [DW-1:0]   prdata_q, prdata_d;
   logic            pready_q, pready_d;
   logic            pslverr_q, pslverr_d;
   logic [EW-1:0]   err_count_q, err_count_d;

   logic            setup_c;
   logic            setup_err_c;

   // Error is decided once, from the address and config_mode seen in the setup phase.
   assign setup_c     = apb.psel && !apb.penable;
   assign setup_err_c = (apb.paddr >= K_ADDR) || (apb.pwrite && !config_mode);

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         state_q      <= ST_IDLE;
         write_q      <= 1'b0;
         err_q        <= 1'b0;
         mem_paddr_q  <= '0;
         mem_pwdata_q <= '0;
         mem_pwrite_q <= 1'b0;
         mem_wr_en_q  <= 1'b0;
         prdata_q     <= '0;
         pready_q     <= 1'b0;
         pslverr_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         err_q        <= err_d;
         mem_paddr_q  <= mem_paddr_d;
         mem_pwdata_q <= mem_pwdata_d;
         mem_pwrite_q <= mem_pwrite_d;
         mem_wr_en_q  <= mem_wr_en_d;
         prdata_q     <= prdata_d;
         pready_q     <= pready_d;
         pslverr_q    <= pslverr_d;
         err_count_q  <= err_count_d;
      end
   end

   // Next-state logic; outputs are loaded one cycle ahead so they appear registered in the target state.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      err_d        = err_q;
      mem_paddr_d  = mem_paddr_q;
      mem_pwdata_d = mem_pwdata_q;
      mem_pwrite_d = 1'b0;
      mem_wr_en_d  = 1'b0;
      prdata_d     = '0;
      pready_d     = 1'b0;
      pslverr_d    = 1'b0;
      err_count_d  = err_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (setup_c) begin
               state_d      = ST_MEM;
               write_d      = apb.pwrite;
               err_d        = setup_err_c;
               mem_paddr_d  = setup_err_c ? '0 : apb.paddr;
               mem_pwdata_d = apb.pwdata;
               mem_pwrite_d = apb.pwrite && !setup_err_c;
               mem_wr_en_d  = apb.pwrite && !setup_err_c;
            end
         end
         ST_MEM: begin
            if (!apb.psel) begin
               state_d = ST_IDLE;
            end else if (write_q) begin
               state_d   = ST_DONE;
               pready_d  = 1'b1;
               pslverr_d = err_q;
               if (err_q && (err_count_q != ECNT_MAX)) err_count_d = err_count_q + EW'(1);
            end else begin
               state_d = ST_CAP;
            end
         end
         ST_CAP: begin
            if (!apb.psel) begin
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_DONE;
               pready_d  = 1'b1;
               pslverr_d = err_q;
               prdata_d  = err_q ? '0 : mem_prdata;
               if (err_q && (err_count_q != ECNT_MAX)) err_count_d = err_count_q + EW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign apb.prdata  = prdata_q;
   assign apb.pready  = pready_q;
   assign apb.pslverr = pslverr_q;
   assign mem_paddr   = mem_paddr_q;
   assign mem_pwdata  = mem_pwdata_q;
   assign mem_pwrite  = mem_pwrite_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_apb_config_slave.sv
// Bench for apb_config_slave: transaction-level model schedules per-cycle expectations,
// a negedge compare process checks them, and a small registered-read memory stands in for config_mem.
module tb_apb_config_slave;

   logic        pclk;
   logic        prstn;
   logic        config_mode;
   logic [15:0] mem_paddr;
   logic [31:0] mem_pwdata;
   logic        mem_pwrite;
   logic        mem_wr_en;
   logic [31:0] mem_prdata;
   logic [7:0]  err_count;

   apb_config_slave_if #(.AW(16)) bus ();

   apb_config_slave #(.K(64), .AW(16)) dut (
      .pclk        (pclk),
      .prstn       (prstn),
      .apb         (bus),
      .config_mode (config_mode),
      .mem_paddr   (mem_paddr),
      .mem_pwdata  (mem_pwdata),
      .mem_pwrite  (mem_pwrite),
      .mem_wr_en   (mem_wr_en),
      .mem_prdata  (mem_prdata),
      .err_count   (err_count)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
   endfunction

   // config_mem stand-in: 1-cycle registered read, write on mem_pwrite && mem_wr_en.
   logic [31:0] cmem [64];
   bit          cmem_init = 1'b0;
   always @(posedge pclk) begin
      if (!cmem_init) begin
         for (int i = 0; i < 64; i++) cmem[i] <= pat(i);
         cmem_init  <= 1'b1;
         mem_prdata <= '0;
      end else begin
         if (mem_pwrite && mem_wr_en) cmem[mem_paddr[5:0]] <= mem_pwdata;
         mem_prdata <= cmem[mem_paddr[5:0]];
      end
   end

   // Reference model state and per-cycle expectations keyed by cycle index.
   logic [31:0] ref_mem [64];
   int          model_ecnt = 0;
   bit          exp_pready  [int];
   logic        exp_pslverr [int];
   logic [31:0] exp_prdata  [int];
   logic [31:0] exp_strobe  [int];
   logic [15:0] exp_maddr   [int];
   logic [7:0]  exp_ecnt    [int];
   logic [7:0]  cur_ecnt = 8'd0;

   logic [31:0] last_prdata;
   logic        last_pslverr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge pclk) begin
      if (exp_ecnt.exists(cyc)) cur_ecnt = exp_ecnt[cyc];
      if (!prstn) begin
         chk("rst_prdata", bus.prdata, 32'h0);
         chk("rst_flags", 32'({bus.pready, bus.pslverr, mem_pwrite, mem_wr_en}), 32'h0);
         chk("rst_maddr", 32'(mem_paddr), 32'h0);
         chk("rst_mwdata", mem_pwdata, 32'h0);
         chk("rst_ecnt", 32'(err_count), 32'h0);
      end else begin
         chk("pready", 32'(bus.pready), 32'(exp_pready.exists(cyc)));
         if (exp_pready.exists(cyc)) begin
            chk("pslverr", 32'(bus.pslverr), 32'(exp_pslverr[cyc]));
            chk("prdata", bus.prdata, exp_prdata[cyc]);
         end else begin
            chk("pslverr_idle", 32'(bus.pslverr), 32'h0);
            chk("err_count", 32'(err_count), 32'(cur_ecnt));
         end
         chk("mem_pwrite", 32'(mem_pwrite), 32'(exp_strobe.exists(cyc)));
         chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_strobe.exists(cyc)));
         if (exp_strobe.exists(cyc)) chk("mem_pwdata", mem_pwdata, exp_strobe[cyc]);
         if (exp_maddr.exists(cyc)) chk("mem_paddr", 32'(mem_paddr), 32'(exp_maddr[cyc]));
      end
   end

   // abort: 0 none, 1 drop psel in MEM, 2 drop psel in CAP. flip toggles config_mode after setup.
   task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input int abort, input bit flip);
      int   s;
      int   done;
      logic e;
      @(negedge pclk);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = wr;
      bus.paddr   = a;
      bus.pwdata  = d;
      s = cyc + 1;
      e = (a >= 16'd64) || (wr && !config_mode);
      exp_maddr[s] = e ? 16'h0 : a;
      if (wr && !e) begin
         exp_strobe[s]    = d;
         ref_mem[a[5:0]] = d;
      end
      if (abort == 0) begin
         done = s + (wr ? 1 : 2);
         exp_pready[done]  = 1'b1;
         exp_pslverr[done] = e;
         exp_prdata[done]  = (wr || e) ? 32'h0 : ref_mem[a[5:0]];
         if (e) begin
            if (model_ecnt < 255) model_ecnt++;
            exp_ecnt[done + 1] = 8'(model_ecnt);
         end
      end
      @(negedge pclk);
      if (flip) config_mode = ~config_mode;
      if (abort == 1) begin
         bus.psel    = 1'b0;
         bus.penable = 1'b0;
      end else begin
         bus.penable = 1'b1;
      end
      if (abort == 2) begin
         @(negedge pclk);
         bus.psel    = 1'b0;
         bus.penable = 1'b0;
      end
      if (abort == 0) begin
         repeat (wr ? 1 : 2) @(negedge pclk);
         last_prdata  = bus.prdata;
         last_pslverr = bus.pslverr;
      end
   endtask

   task automatic idle(input int n);
      @(negedge pclk);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      repeat (n) @(negedge pclk);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
      prstn       = 1'b0;
      config_mode = 1'b1;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b0;
      bus.paddr   = '0;
      bus.pwdata  = '0;
      repeat (3) @(negedge pclk);
      prstn = 1'b1;
      idle(1);

      // 1/2: good write then back-to-back read of the same word
      xfer(1'b1, 16'd5, 32'hDEADBEEF, 0, 1'b0);
      chk("t1_pslverr", 32'(last_pslverr), 32'h0);
      xfer(1'b0, 16'd5, 32'h0, 0, 1'b0);
      chk("t2_prdata", last_prdata, 32'hDEADBEEF);
      chk("t2_pslverr", 32'(last_pslverr), 32'h0);

      // 3: write outside config mode is refused and counted
      config_mode = 1'b0;
      xfer(1'b1, 16'd3, 32'h1111_2222, 0, 1'b0);
      chk("t3_pslverr", 32'(last_pslverr), 32'h1);
      idle(1);
      chk("t3_ecnt", 32'(err_count), 32'h1);
      xfer(1'b0, 16'd3, 32'h0, 0, 1'b0);
      chk("t3_word_kept", last_prdata, 32'hC0DE_0303);

      // 4: out-of-range reads, no aliasing, then saturation
      xfer(1'b0, 16'd64, 32'h0, 0, 1'b0);
      chk("t4_prdata", last_prdata, 32'h0);
      chk("t4_pslverr", 32'(last_pslverr), 32'h1);
      xfer(1'b0, 16'd69, 32'h0, 0, 1'b0);
      xfer(1'b0, 16'hFFFF, 32'h0, 0, 1'b0);
      for (int i = 0; i < 300; i++) xfer(1'b0, 16'd64, 32'h0, 0, 1'b0);
      idle(1);
      chk("t4_ecnt_sat", 32'(err_count), 32'd255);

      // last valid word, and config_mode changes after setup
      config_mode = 1'b1;
      xfer(1'b1, 16'd63, 32'hA5A5_5A5A, 0, 1'b0);
      xfer(1'b0, 16'd63, 32'h0, 0, 1'b0);
      chk("k_minus_1", last_prdata, 32'hA5A5_5A5A);
      xfer(1'b1, 16'd7, 32'h0000_0777, 0, 1'b1);
      chk("flip_ok", 32'(last_pslverr), 32'h0);
      xfer(1'b1, 16'd8, 32'h0000_0888, 0, 1'b1);
      chk("flip_err", 32'(last_pslverr), 32'h1);
      xfer(1'b0, 16'd7, 32'h0, 0, 1'b0);

      // 5: aborts, then normal reads still work
      xfer(1'b0, 16'd5, 32'h0, 2, 1'b0);
      xfer(1'b0, 16'd5, 32'h0, 0, 1'b0);
      chk("t5_prdata", last_prdata, 32'hDEADBEEF);
      xfer(1'b1, 16'd9, 32'h0909_0909, 1, 1'b0);
      xfer(1'b0, 16'd9, 32'h0, 0, 1'b0);
      chk("abort_wr_kept", last_prdata, 32'h0909_0909);

      // access phase without a setup phase is ignored
      @(negedge pclk);
      bus.psel    = 1'b1;
      bus.penable = 1'b1;
      bus.pwrite  = 1'b1;
      bus.paddr   = 16'd5;
      bus.pwdata  = 32'hBAD0_BAD0;
      repeat (3) @(negedge pclk);
      idle(1);

      // 6: reset during MEM of a write
      @(negedge pclk);
      bus.psel    = 1'b1;
      bus.penable = 1'b0;
      bus.pwrite  = 1'b1;
      bus.paddr   = 16'd10;
      bus.pwdata  = 32'h1234_5678;
      @(posedge pclk);
      #1;
      chk("t6_strobe_pre", 32'(mem_pwrite), 32'h1);
      #1;
      prstn = 1'b0;
      exp_pready.delete();
      exp_strobe.delete();
      exp_maddr.delete();
      exp_ecnt.delete();
      model_ecnt    = 0;
      exp_ecnt[cyc] = 8'd0;
      #1;
      chk("t6_pwrite", 32'(mem_pwrite), 32'h0);
      chk("t6_wr_en", 32'(mem_wr_en), 32'h0);
      chk("t6_ecnt", 32'(err_count), 32'h0);
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      prstn = 1'b1;
      xfer(1'b0, 16'd10, 32'h0, 0, 1'b0);
      chk("t6_word_kept", last_prdata, 32'hC0DE_0A0A);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
